norm_shift_ctrl: RTL and testbench
==================================

NORM_SHIFT_CTRL -- requirements
Module: norm_shift_ctrl

Interface
- Parameters: one per line, as name, default, meaning.
- Ports: one per line, as name, direction, width, meaning.

REQ-001 SHALL have parameter DW, 16, data width.
REQ-002 SHALL have parameter SW, 4, shift-amount width; DW == 2**SW is required, checked by an elaboration-time assertion.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1, upstream word present.
REQ-006 SHALL have port in_ready, output, 1, block can accept a word this cycle.
REQ-007 SHALL have port in_data, input, DW, word to normalise.
REQ-008 SHALL have port out_valid, output, 1, result present.
REQ-009 SHALL have port out_ready, input, 1, downstream (barrel shifter consumer) accepts the result.
REQ-010 SHALL have port out_data, output, DW, unshifted word, wired straight to the left barrel shifter data input.
REQ-011 SHALL have port out_shift, output, SW, left-shift amount for the barrel shifter.
REQ-012 SHALL have port out_zero, output, 1, word was all zeros.

Function
REQ-013 SHALL transfer a word in when in_valid && in_ready, and a result out when out_valid && out_ready.
REQ-014 SHALL be a 2-stage pipeline:
- S1 registers in_data plus a valid bit.
- S2 registers data, the leading-zero count of the S1 data, the zero flag, and a valid bit.
REQ-015 SHALL have latency of exactly 2 cycles from input accept to out_valid when out_ready is held high.
REQ-016 SHALL set out_shift = number of leading zeros of out_data (0..DW-1), so that out_data << out_shift has bit DW-1 set.
REQ-017 SHALL, for out_data == 0, drive out_shift = 0 and out_zero = 1; otherwise out_zero = 0.
REQ-018 SHALL advance S2 when S2 is empty or out_ready = 1; S1 advances when S1 is empty or S2 advances.
REQ-019 SHALL drive in_ready = !s1_valid || s2_advance (combinational, no bubble under full throughput).
REQ-020 SHALL sustain 1 word/cycle throughput with out_ready held high.
REQ-021 SHALL hold out_data, out_shift and out_zero stable while out_valid && !out_ready.
REQ-022 SHALL lose, duplicate or reorder no word under any back-pressure pattern.
REQ-023 SHALL, when S2 drains while S1 loads in the same cycle, take both actions and lose nothing.
REQ-024 SHALL hold 2 words when out_ready is low: in_ready drops after both stages fill.
REQ-025 SHALL NOT let in_valid or in_data influence outputs other than via registered stages (no combinational in->out path except in_ready from out_ready).

Reset
REQ-026 SHALL, while rst is high at a clock edge, clear s1_valid and s2_valid; out_valid = 0, out_data = 0, out_shift = 0, out_zero = 0.
REQ-027 SHALL drive in_ready = 1 on the first cycle after rst deasserts.
REQ-028 SHALL discard in-flight words when reset is asserted mid-operation, and SHALL NOT emit them afterwards.
REQ-029 SHALL ignore in_valid during reset.

Structure
REQ-030 SHALL place constants DW = 16 and SW = 4 in shared package norm_pkg, alongside a typedef for the {data, shift, zero} result record.
REQ-031 SHALL put the leading-zero count in sub-module lzc16:
- combinational;
- input DW bits;
- outputs count[SW-1:0] and zero.
REQ-032 SHALL keep the pipeline valid/ready control in norm_shift_ctrl itself; no further sub-modules.

Verification
REQ-033 SHALL cover: in_data 0x0001 -> out_data 0x0001, out_shift 15, out_zero 0, out_valid 2 cycles after accept.
REQ-034 SHALL cover: in_data 0x8000 -> out_shift 0, out_zero 0; in_data 0x00F0 -> out_shift 8.
REQ-035 SHALL cover: in_data 0x0000 -> out_shift 0, out_zero 1.
REQ-036 SHALL cover: words 0x0003, 0x0400, 0x7FFF sent back-to-back, out_ready low for 3 cycles, then high:
- in_ready drops after 2 accepts;
- outputs are shifts 14, 5, 1 in order;
- outputs are held stable while stalled.
REQ-037 SHALL cover: rst pulsed 1 cycle with both stages full -> next cycle out_valid 0, all outputs 0, in_ready 1; the discarded words never appear.
REQ-038 SHALL cover: 100 random words with random out_ready, checked against a scoreboard -> out_data << out_shift has MSB set for every nonzero word, and throughput is 1/cycle whenever out_ready = 1.

Source files
------------

// File: rtl/norm_pkg.sv
// Shared constants and the result record for the leading-zero normaliser.
package norm_pkg;

    localparam int DW = 16;
    localparam int SW = 4;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [SW-1:0] shift;
        logic          zero;
    } norm_result_t;

endpackage

// File: rtl/norm_shift_ctrl_lzc16.sv
// Combinational leading-zero counter; count is 0 and zero is set for an all-zero word.
module lzc16
    import norm_pkg::*;
(
    input  logic [DW-1:0] data,
    output logic [SW-1:0] count,
    output logic          zero
);

    // Scan from LSB upward so the highest set bit is the last one to write count.
    always_comb begin
        count = '0;
        zero  = 1'b1;
        for (int i = 0; i < DW; i++) begin
            if (data[i]) begin
                count = SW'(DW - 1 - i);
                zero  = 1'b0;
            end
        end
    end

endmodule

// File: rtl/norm_shift_ctrl.sv
// Two-stage valid/ready pipeline producing the left-shift amount that normalises a word.
module norm_shift_ctrl #(
    parameter int DW = norm_pkg::DW,
    parameter int SW = norm_pkg::SW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [SW-1:0] out_shift,
    output logic          out_zero
);

    import norm_pkg::*;

    // The counter and result record are sized by the package, so the overrides must agree.
    generate
        if (DW != 2 ** SW || DW != norm_pkg::DW || SW != norm_pkg::SW) begin : g_bad_cfg
            $error("norm_shift_ctrl: DW must equal 2**SW and match norm_pkg");
        end
    endgenerate

    logic          s1_valid_q;
    logic          s1_valid_d;
    logic [DW-1:0] s1_data_q;
    logic [DW-1:0] s1_data_d;
    logic          s2_valid_q;
    logic          s2_valid_d;
    norm_result_t  s2_q;
    norm_result_t  s2_d;

    logic          s1_advance;
    logic          s2_advance;
    logic [SW-1:0] lz_count;
    logic          lz_zero;

    lzc16 u_lzc (
        .data  (s1_data_q),
        .count (lz_count),
        .zero  (lz_zero)
    );

    assign s2_advance = !s2_valid_q || out_ready;
    assign s1_advance = !s1_valid_q || s2_advance;
    assign in_ready   = s1_advance;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        s2_valid_d = s2_valid_q;
        s2_d       = s2_q;

        if (s1_advance) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_data_d = in_data;
            end
        end

        // Only a real word overwrites S2, so held outputs never change under a bubble.
        if (s2_advance) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_d.data  = s1_data_q;
                s2_d.shift = lz_count;
                s2_d.zero  = lz_zero;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_q       <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s2_valid_q <= s2_valid_d;
            s2_q       <= s2_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_data  = s2_q.data;
    assign out_shift = s2_q.shift;
    assign out_zero  = s2_q.zero;

endmodule

// File: tb/tb_norm_shift_ctrl.sv
// Self-checking bench for norm_shift_ctrl: directed cases, back-pressure, reset, random traffic.
module tb_norm_shift_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = 16'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic [3:0]  out_shift;
    logic        out_zero;

    norm_shift_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_shift (out_shift),
        .out_zero  (out_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        int          shift;
        logic        zero;
        int          acc;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic        prev_stall = 1'b0;
    logic [15:0] prev_data;
    logic [3:0]  prev_shift;
    logic        prev_zero;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Normalising shift = DW minus the bit-length of the word.
    function automatic int ref_shift(input logic [15:0] w);
        if (w == 16'h0) return 0;
        return 16 - $clog2(int'(w) + 1);
    endfunction

    // One clock cycle: drive inputs, check outputs against the model, update the model.
    task automatic step(input logic v, input logic [15:0] d, input logic ordy,
                        input int dir_shift, input int dir_zero, output logic acc);
        logic        exp_valid;
        logic        exp_ready;
        logic [15:0] norm;
        exp_t        e;
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        #1;
        exp_valid = (q.size() > 0) && (cyc - q[0].acc >= 2);
        exp_ready = (q.size() < 2) || ordy;
        chk("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
        chk("out_valid", {31'd0, out_valid}, {31'd0, exp_valid});
        if (exp_valid) begin
            chk("out_data", {16'd0, out_data}, {16'd0, q[0].data});
            chk("out_shift", {28'd0, out_shift}, q[0].shift);
            chk("out_zero", {31'd0, out_zero}, {31'd0, q[0].zero});
            if (q[0].data != 16'h0) begin
                norm = out_data << out_shift;
                chk("norm_msb", {31'd0, norm[15]}, 32'd1);
            end
        end
        if (prev_stall) begin
            chk("stall_data", {16'd0, out_data}, {16'd0, prev_data});
            chk("stall_shift", {28'd0, out_shift}, {28'd0, prev_shift});
            chk("stall_zero", {31'd0, out_zero}, {31'd0, prev_zero});
        end
        prev_stall = exp_valid && !ordy;
        prev_data  = out_data;
        prev_shift = out_shift;
        prev_zero  = out_zero;
        acc = v && exp_ready;
        if (exp_valid && ordy) void'(q.pop_front());
        if (acc) begin
            e.data  = d;
            e.shift = (dir_shift >= 0) ? dir_shift : ref_shift(d);
            e.zero  = (dir_zero >= 0) ? dir_zero[0] : (d == 16'h0);
            e.acc   = cyc;
            q.push_back(e);
        end
        $display("cyc %0d in_v=%0b in_d=%04h in_rdy=%0b out_v=%0b out_rdy=%0b out_d=%04h sh=%0d z=%0b",
                 cyc, v, d, in_ready, out_valid, ordy, out_data, out_shift, out_zero);
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_data   = 16'hFFFF;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        cyc++;
        q.delete();
        prev_stall = 1'b0;
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", {16'd0, out_data}, 32'd0);
        chk("rst_out_shift", {28'd0, out_shift}, 32'd0);
        chk("rst_out_zero", {31'd0, out_zero}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        $display("reset released at cyc %0d", cyc);
    endtask

    function automatic logic [15:0] gen_word();
        logic [15:0] w;
        case ($urandom_range(0, 3))
            0: w = 16'($urandom);
            1: w = 16'h1 << $urandom_range(0, 15);
            2: w = 16'h0;
            default: w = 16'($urandom) >> $urandom_range(0, 15);
        endcase
        return w;
    endfunction

    initial begin
        logic a;
        int   sent;
        int   guard;

        @(posedge clk);
        @(posedge clk);
        #1;
        do_reset();

        // Single words with known answers, full throughput downstream.
        step(1'b1, 16'h0001, 1'b1, 15, 0, a);
        repeat (3) step(1'b0, 16'h0, 1'b1, -1, -1, a);
        step(1'b1, 16'h8000, 1'b1, 0, 0, a);
        step(1'b1, 16'h00F0, 1'b1, 8, 0, a);
        step(1'b1, 16'h0000, 1'b1, 0, 1, a);
        repeat (3) step(1'b0, 16'h0, 1'b1, -1, -1, a);

        // Back-to-back words against a 3-cycle stall.
        step(1'b1, 16'h0003, 1'b0, 14, 0, a);
        step(1'b1, 16'h0400, 1'b0, 5, 0, a);
        repeat (3) begin
            step(1'b1, 16'h7FFF, 1'b0, 1, 0, a);
            chk("stall_no_accept", {31'd0, a}, 32'd0);
        end
        guard = 0;
        a = 1'b0;
        while (!a && guard < 10) begin
            step(1'b1, 16'h7FFF, 1'b1, 1, 0, a);
            guard++;
        end
        if (!a) chk("stall_resume_timeout", guard, 32'd0);
        repeat (4) step(1'b0, 16'h0, 1'b1, -1, -1, a);

        // Reset with both stages full: the two words must vanish.
        step(1'b1, 16'h1234, 1'b0, -1, -1, a);
        step(1'b1, 16'h0042, 1'b0, -1, -1, a);
        do_reset();
        repeat (4) step(1'b0, 16'h0, 1'b1, -1, -1, a);

        // Full-throughput burst.
        repeat (8) step(1'b1, gen_word(), 1'b1, -1, -1, a);
        repeat (3) step(1'b0, 16'h0, 1'b1, -1, -1, a);

        // Random traffic with random back-pressure.
        sent  = 0;
        guard = 0;
        while (sent < 100 && guard < 3000) begin
            step($urandom_range(0, 3) != 0, gen_word(), $urandom_range(0, 2) != 0, -1, -1, a);
            if (a) sent++;
            guard++;
        end
        if (sent < 100) chk("random_timeout", sent, 32'd100);
        repeat (4) step(1'b0, 16'h0, 1'b1, -1, -1, a);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
